// File: rtl/fifo_share_ctrl.sv
// Shares one 8-deep FIFO between two round-robin write requesters and a valid/ready reader.
// Optional ARB_STATS_EN adds per-requester write counters and a full-stall counter.
module fifo_share_ctrl #(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack1,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  output logic          cons_valid,
  input  logic          cons_ready,
  output logic [DW-1:0] cons_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   wr_cnt0,
  output logic [15:0]   wr_cnt1,
  output logic [15:0]   stall_cnt
`endif
);

  if (CW < 4) begin : g_cw_check
    $error("CW must hold the occupancy range 0..8");
  end

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

  rd_state_t state_reg, state_next;
  logic      rr_ptr_reg;
  logic      grant0, grant1;

  // Both FIFO strobes are held off during reset so its contents survive.
  assign grant0   = ~reset & ~fifo_full & req0 & (~req1 | ~rr_ptr_reg);
  assign grant1   = ~reset & ~fifo_full & req1 & (~req0 |  rr_ptr_reg);
  assign ack0     = grant0;
  assign ack1     = grant1;
  assign fifo_wr  = grant0 | grant1;
  assign fifo_din = grant1 ? data1 : data0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else if (grant0) begin
      rr_ptr_reg <= 1'b1;
    end else if (grant1) begin
      rr_ptr_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fifo_rd) state_next = FETCH;
      FETCH:   state_next = HOLD;
      HOLD:    if (cons_ready) state_next = fifo_rd ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd = 1'b0;
    case (state_reg)
      IDLE:    fifo_rd = ~fifo_empty;
      HOLD:    fifo_rd = cons_ready & ~fifo_empty;
      default: fifo_rd = 1'b0;
    endcase
    if (reset) fifo_rd = 1'b0;
  end

  // FIFO read data is registered, so it is captured one cycle after fifo_rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      cons_valid <= 1'b0;
      cons_data  <= '0;
    end else if (state_reg == FETCH) begin
      cons_valid <= 1'b1;
      cons_data  <= fifo_dout;
    end else if (state_reg == HOLD && cons_ready) begin
      cons_valid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt0   <= '0;
      wr_cnt1   <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant0) wr_cnt0 <= wr_cnt0 + 16'd1;
      if (grant1) wr_cnt1 <= wr_cnt1 + 16'd1;
      if ((req0 | req1) && fifo_full && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed bench for fifo_share_ctrl with a behavioural 8x32 FIFO (registered read) attached.
// Define ARB_STATS_EN on both files to exercise the statistics counters.
module tb_fifo_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, ack0, ack1;
  logic [31:0] data0, data1;
  logic        fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [31:0] fifo_din, fifo_dout;
  logic        cons_valid, cons_ready;
  logic [31:0] cons_data;
`ifdef ARB_STATS_EN
  logic [15:0] wr_cnt0, wr_cnt1, stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_share_ctrl #(.DW(32), .CW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .data1      (data1),
    .ack1       (ack1),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready),
    .cons_data  (cons_data)
`ifdef ARB_STATS_EN
    ,
    .wr_cnt0    (wr_cnt0),
    .wr_cnt1    (wr_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Behavioural FIFO; cleared only by fifo_clr so DUT resets leave it intact.
  logic        fifo_clr;
  logic [31:0] mem [8];
  logic [3:0]  cnt;
  logic [2:0]  wp, rp;
  logic        wr_ok, rd_ok;

  assign fifo_full  = (cnt == 4'd8);
  assign fifo_empty = (cnt == 4'd0);
  assign wr_ok      = fifo_wr && !fifo_full;
  assign rd_ok      = fifo_rd && !fifo_empty;

  always @(posedge clk) begin
    if (fifo_clr) begin
      cnt       <= '0;
      wp        <= '0;
      rp        <= '0;
      fifo_dout <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 3'd1;
      end
      if (rd_ok) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 3'd1;
      end
      cnt <= cnt + {3'd0, wr_ok} - {3'd0, rd_ok};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!cons_valid && n < 20) begin
      step();
      n++;
    end
    if (!cons_valid) check("valid_timeout", {31'd0, cons_valid}, 32'd1);
  endtask

  task automatic consume(input string tag, input logic [31:0] exp);
    cons_ready = 1'b1;
    settle();
    wait_valid();
    check(tag, cons_data, exp);
    step();
    cons_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fifo_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; cons_ready = 1'b0;

    // T1: reset
    step(); step();
    check("t1_cons_valid", {31'd0, cons_valid}, 32'd0);
    check("t1_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check("t1_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("t1_cons_data", cons_data, 32'd0);
    reset = 1'b0; fifo_clr = 1'b0;

    // T2: contention, alternating grants starting with req0
    req0 = 1'b1; req1 = 1'b1; data0 = 32'hA000_0000; data1 = 32'hB000_0000;
    settle();
    check("t2_ack0_a", {31'd0, ack0}, 32'd1);
    check("t2_ack1_a", {31'd0, ack1}, 32'd0);
    check("t2_din_a", fifo_din, 32'hA000_0000);
    step(); data0 = 32'hA000_0001; settle();
    check("t2_ack1_b", {31'd0, ack1}, 32'd1);
    check("t2_din_b", fifo_din, 32'hB000_0000);
    step(); data1 = 32'hB000_0001; settle();
    check("t2_ack0_c", {31'd0, ack0}, 32'd1);
    check("t2_din_c", fifo_din, 32'hA000_0001);
    step(); settle();
    check("t2_ack1_d", {31'd0, ack1}, 32'd1);
    check("t2_din_d", fifo_din, 32'hB000_0001);
    step(); req0 = 1'b0; req1 = 1'b0;
    consume("t2_rd0", 32'hA000_0000);
    consume("t2_rd1", 32'hB000_0000);
    consume("t2_rd2", 32'hA000_0001);
    consume("t2_rd3", 32'hB000_0001);

    // T3: full. The reader prefetches one word into cons_data, so the FIFO
    // itself becomes full on the 9th accepted write and the 10th stalls.
    req1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      data1 = 32'hD000_0000 + k;
      settle();
      check($sformatf("t3_ack1_w%0d", k), {31'd0, ack1}, 32'd1);
      step();
    end
    data1 = 32'hD000_0009;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("t3_stall_ack1_%0d", k), {31'd0, ack1}, 32'd0);
      check($sformatf("t3_stall_wr_%0d", k), {31'd0, fifo_wr}, 32'd0);
      step();
    end
    cons_ready = 1'b1; settle();
    check("t3_hold_valid", {31'd0, cons_valid}, 32'd1);
    check("t3_rd0", cons_data, 32'hD000_0000);
    step(); cons_ready = 1'b0; settle();
    check("t3_resume_ack1", {31'd0, ack1}, 32'd1);
    step(); req1 = 1'b0;
    for (int k = 1; k < 10; k++) consume($sformatf("t3_rd%0d", k), 32'hD000_0000 + k);

    // T4: empty FIFO never read; first word valid 2 cycles after empty falls
    cons_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("t4_no_rd_%0d", k), {31'd0, fifo_rd}, 32'd0);
      step();
    end
    req0 = 1'b1; data0 = 32'h1234_5678; settle();
    check("t4_ack0", {31'd0, ack0}, 32'd1);
    step(); req0 = 1'b0; settle();
    check("t4_rd_issued", {31'd0, fifo_rd}, 32'd1);
    step();
    check("t4_fetch_valid", {31'd0, cons_valid}, 32'd0);
    step();
    check("t4_valid", {31'd0, cons_valid}, 32'd1);
    check("t4_data", cons_data, 32'h1234_5678);
    step();
    check("t4_accepted", {31'd0, cons_valid}, 32'd0);
    cons_ready = 1'b0;

    // T5: backpressure holds data, no further reads
    req0 = 1'b1; data0 = 32'hE000_0000;
    step(); data0 = 32'hE000_0001;
    step(); req0 = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("t5_data_%0d", k), cons_data, 32'hE000_0000);
      check($sformatf("t5_no_rd_%0d", k), {31'd0, fifo_rd}, 32'd0);
      step();
    end
    consume("t5_rd0", 32'hE000_0000);
    consume("t5_rd1", 32'hE000_0001);

    // T6: reset mid-transfer drops the held word; statistics
    req0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data0 = 32'hC000_0000 + k;
      step();
    end
    req0 = 1'b0;
    step(); step(); step();
    check("t6_pre_hold", cons_data, 32'hC000_0000);
    reset = 1'b1;
    step(); step(); settle();
    check("t6_rst_valid", {31'd0, cons_valid}, 32'd0);
    check("t6_rst_rd", {31'd0, fifo_rd}, 32'd0);
`ifdef ARB_STATS_EN
    check("t6_rst_cnt0", {16'd0, wr_cnt0}, 32'd0);
    check("t6_rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    reset = 1'b0;
    req0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data0 = 32'hF000_0000 + k; settle();
      check($sformatf("t6_ack0_%0d", k), {31'd0, ack0}, 32'd1);
      step();
    end
    check("t6_after_rst_valid", {31'd0, cons_valid}, 32'd1);
    check("t6_after_rst_data", cons_data, 32'hC000_0001);
    req0 = 1'b0; req1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data1 = 32'hF100_0000 + k; settle();
      check($sformatf("t6_ack1_%0d", k), {31'd0, ack1}, 32'd1);
      step();
    end
    data1 = 32'hF100_0002;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("t6_stall_%0d", k), {31'd0, ack1}, 32'd0);
      step();
    end
    req1 = 1'b0;
`ifdef ARB_STATS_EN
    check("t6_wr_cnt0", {16'd0, wr_cnt0}, 32'd3);
    check("t6_wr_cnt1", {16'd0, wr_cnt1}, 32'd2);
    check("t6_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_clr_cnt0", {16'd0, wr_cnt0}, 32'd0);
    check("t6_clr_cnt1", {16'd0, wr_cnt1}, 32'd0);
    check("t6_clr_stall", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
